boron_xor_layer_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 64-bit Boron decrypt XOR layer.
- Provides the forward (encrypt) and inverse (decrypt) Boron XOR-mix layers, selectable per block.
- Uses a configurable-latency pipeline with full valid/ready backpressure.
- Sits between the S-box layer and the round-key/permutation stage in both the encrypt and decrypt round datapaths.

---
 rtl/boron_xor_layer_pipe.sv | 153 +++++++++++++++
 tb/tb_boron_xor_layer_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boron_xor_layer_pipe.sv
// Boron XOR-mix layer (forward/inverse, selectable per block) behind a LAT-deep valid/ready pipeline.
// Optional shadow self-check enabled by defining BORON_XOR_SELFCHECK_EN.
module boron_xor_layer_pipe #(
    parameter int WORD_W = 16,
    parameter int LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*WORD_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [4*WORD_W-1:0]   out_data,
    output logic [15:0]           blk_cnt,
    output logic                  chk_err
);
    localparam int BLK_W = 4 * WORD_W;

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("boron_xor_layer_pipe: LAT must be in 1..4");
    end

    // enc=1 is the forward layer, enc=0 its exact inverse.
    function automatic logic [BLK_W-1:0] xor_mix(input logic enc, input logic [BLK_W-1:0] d);
        logic [WORD_W-1:0] w0, w1, w2, w3;
        logic [WORD_W-1:0] y0, y1, y2, y3;
        w0 = d[WORD_W-1:0];
        w1 = d[2*WORD_W-1:WORD_W];
        w2 = d[3*WORD_W-1:2*WORD_W];
        w3 = d[4*WORD_W-1:3*WORD_W];
        if (enc) begin
            y0 = w3 ^ w1 ^ w0;
            y1 = w3 ^ w1;
            y2 = w2 ^ w0;
            y3 = w3 ^ w2 ^ w0;
        end else begin
            y0 = w1 ^ w0;
            y1 = w3 ^ w2 ^ w1;
            y2 = w2 ^ w1 ^ w0;
            y3 = w3 ^ w2;
        end
        return {y3, y2, y1, y0};
    endfunction

    logic              v_reg    [LAT];
    logic              mode_reg [LAT];
    logic [BLK_W-1:0]  data_reg [LAT];
    logic [LAT:0]      load;
    logic [BLK_W-1:0]  mixed;
    logic [15:0]       blk_cnt_reg;
    logic              xfer;

    // load[k]: stage k may capture this cycle; load[LAT] is the downstream sink.
    always_comb begin
        load = '0;
        load[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            load[k] = !v_reg[k] || load[k+1];
        end
    end

    assign mixed = xor_mix(in_mode, in_data);

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic             src_v;
        logic             src_m;
        logic [BLK_W-1:0] src_d;

        if (gi == 0) begin : g_head
            assign src_v = in_valid;
            assign src_m = in_mode;
            assign src_d = mixed;
        end else begin : g_body
            assign src_v = v_reg[gi-1];
            assign src_m = mode_reg[gi-1];
            assign src_d = data_reg[gi-1];
        end

        // Payload only changes when a real block arrives, so a stalled or idle stage holds.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_reg[gi]    <= 1'b0;
                mode_reg[gi] <= 1'b0;
                data_reg[gi] <= '0;
            end else if (load[gi]) begin
                v_reg[gi] <= src_v;
                if (src_v) begin
                    mode_reg[gi] <= src_m;
                    data_reg[gi] <= src_d;
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_reg[LAT-1];
    assign out_mode  = mode_reg[LAT-1];
    assign out_data  = data_reg[LAT-1];
    assign xfer      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_reg <= '0;
        end else if (xfer) begin
            blk_cnt_reg <= blk_cnt_reg + 16'd1;
        end
    end

    assign blk_cnt = blk_cnt_reg;

`ifdef BORON_XOR_SELFCHECK_EN
    logic [BLK_W-1:0] shadow_reg [LAT];
    logic [BLK_W-1:0] unmixed;
    logic             chk_err_reg;

    for (genvar gi = 0; gi < LAT; gi++) begin : g_shadow
        logic [BLK_W-1:0] shadow_src;

        if (gi == 0) begin : g_head
            assign shadow_src = in_data;
        end else begin : g_body
            assign shadow_src = shadow_reg[gi-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                shadow_reg[gi] <= '0;
            end else if (load[gi] && g_stage[gi].src_v) begin
                shadow_reg[gi] <= shadow_src;
            end
        end
    end

    // Undo the layer on the port value itself, so any corruption after the mix is caught.
    assign unmixed = xor_mix(!out_mode, out_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_reg <= 1'b0;
        end else if (xfer && (unmixed != shadow_reg[LAT-1])) begin
            chk_err_reg <= 1'b1;
        end
    end

    assign chk_err = chk_err_reg;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_boron_xor_layer_pipe.sv
// Directed bench for boron_xor_layer_pipe: three instances (LAT=1, 3, 4) sharing clock and reset.
module tb_boron_xor_layer_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic v1, r1, m1, ov1, or1, om1, e1;
    logic [63:0] d1, od1;
    logic [15:0] c1;
    logic v3, r3, m3, ov3, or3, om3, e3;
    logic [63:0] d3, od3;
    logic [15:0] c3;
    logic v4, r4, m4, ov4, or4, om4, e4;
    logic [63:0] d4, od4;
    logic [15:0] c4;

    boron_xor_layer_pipe #(.WORD_W(16), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_mode(m1), .in_data(d1),
        .out_valid(ov1), .out_ready(or1), .out_mode(om1), .out_data(od1),
        .blk_cnt(c1), .chk_err(e1));
    boron_xor_layer_pipe #(.WORD_W(16), .LAT(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_mode(m3), .in_data(d3),
        .out_valid(ov3), .out_ready(or3), .out_mode(om3), .out_data(od3),
        .blk_cnt(c3), .chk_err(e3));
    boron_xor_layer_pipe #(.WORD_W(16), .LAT(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_mode(m4), .in_data(d4),
        .out_valid(ov4), .out_ready(or4), .out_mode(om4), .out_data(od4),
        .blk_cnt(c4), .chk_err(e4));

    // Reference layer written straight from the word equations.
    function automatic logic [63:0] xf(input logic enc, input logic [63:0] d);
        logic [15:0] w0, w1, w2, w3;
        w0 = d[15:0];
        w1 = d[31:16];
        w2 = d[47:32];
        w3 = d[63:48];
        if (enc) return {w3 ^ w2 ^ w0, w2 ^ w0, w3 ^ w1, w3 ^ w1 ^ w0};
        return {w3 ^ w2, w2 ^ w1 ^ w0, w3 ^ w2 ^ w1, w1 ^ w0};
    endfunction

    task automatic idle_all();
        v1 = 0; m1 = 0; d1 = '0; or1 = 1;
        v3 = 0; m3 = 0; d3 = '0; or3 = 1;
        v4 = 0; m4 = 0; d4 = '0; or4 = 1;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        @(negedge clk);
        checks++;
        if ({ov1, om1, od1, c1, e1, r1} !== {1'b0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_lat1: got v=%b m=%b d=%h cnt=%h err=%b rdy=%b, want 0 0 0 0 0 1", ov1, om1, od1, c1, e1, r1);
        end
        checks++;
        if ({ov3, om3, od3, c3, e3, r3} !== {1'b0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_lat3: got v=%b m=%b d=%h cnt=%h err=%b rdy=%b, want 0 0 0 0 0 1", ov3, om3, od3, c3, e3, r3);
        end
        checks++;
        if ({ov4, om4, od4, c4, e4, r4} !== {1'b0, 1'b0, 64'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_lat4: got v=%b m=%b d=%h cnt=%h err=%b rdy=%b, want 0 0 0 0 0 1", ov4, om4, od4, c4, e4, r4);
        end
        $display("reset: outputs checked on all instances");
    endtask

    task automatic test_single(input logic mode, input logic [63:0] din, input logic [63:0] dexp);
        @(negedge clk);
        v1 = 1; m1 = mode; d1 = din; or1 = 1;
        checks++;
        if (r1 !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b want 1", r1);
        end
        @(negedge clk);
        v1 = 0;
        checks++;
        if (ov1 !== 1'b1 || od1 !== dexp || om1 !== mode) begin
            errors++;
            $display("FAIL single_out mode=%b: got v=%b m=%b d=%h want v=1 m=%b d=%h", mode, ov1, om1, od1, mode, dexp);
        end
        $display("single mode=%b in=%h out=%h", mode, din, od1);
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL single_once mode=%b: out_valid got %b want 0", mode, ov1);
        end
    endtask

    task automatic test_roundtrip();
        logic [63:0] src [1000];
        logic [63:0] mid [1000];
        int bad_dec = 0;
        int bad_enc = 0;
        for (int i = 0; i < 1000; i++) src[i] = {$urandom, $urandom};
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                mid[i-1] = od1;
                if (ov1 !== 1'b1 || om1 !== 1'b0 || od1 !== xf(1'b0, src[i-1])) bad_dec++;
            end
            v1 = (i < 1000); m1 = 0; d1 = (i < 1000) ? src[i] : '0;
        end
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0 && (ov1 !== 1'b1 || om1 !== 1'b1 || od1 !== src[i-1])) bad_enc++;
            v1 = (i < 1000); m1 = 1; d1 = (i < 1000) ? mid[i] : '0;
        end
        v1 = 0;
        checks++;
        if (bad_dec !== 0) begin
            errors++;
            $display("FAIL roundtrip_decrypt: %0d bad blocks, want 0", bad_dec);
        end
        checks++;
        if (bad_enc !== 0) begin
            errors++;
            $display("FAIL roundtrip_encrypt: %0d blocks not restored, want 0", bad_enc);
        end
        $display("roundtrip: 1000 blocks decrypt then encrypt");
    endtask

    task automatic test_back_to_back();
        logic [63:0] blk [10];
        for (int i = 0; i < 10; i++) blk[i] = 64'h0123_4567_89AB_CDEF ^ (64'h0001_0010_0100_1000 * i);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c < 10) begin
                checks++;
                if (r4 !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, r4);
                end
            end
            checks++;
            if (ov4 !== (c >= 4 && c < 14)) begin
                errors++;
                $display("FAIL b2b_valid c=%0d: got %b want %b", c, ov4, (c >= 4 && c < 14));
            end else if (c >= 4 && c < 14) begin
                if (om4 !== 1'((c - 4) % 2) || od4 !== xf(1'((c - 4) % 2), blk[c-4])) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d: got m=%b d=%h want m=%0d d=%h", c, om4, od4, (c - 4) % 2, xf(1'((c - 4) % 2), blk[c-4]));
                end
                $display("b2b out c=%0d mode=%b data=%h", c, om4, od4);
            end
            v4 = (c < 10); m4 = 1'(c % 2); d4 = (c < 10) ? blk[c] : '0;
        end
        checks++;
        if (c4 !== 16'd10) begin
            errors++;
            $display("FAIL b2b_blk_cnt: got %0d want 10", c4);
        end
    endtask

    task automatic test_stall();
        logic [63:0] blk [4];
        blk[0] = 64'h1000_2000_3000_4000;
        blk[1] = 64'hAAAA_5555_FFFF_0000;
        blk[2] = 64'h0F0F_F0F0_1234_8765;
        blk[3] = 64'hDEAD_BEEF_CAFE_F00D;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            or3 = 0; v3 = 1;
            m3 = 1'((c < 3 ? c : 3) % 2);
            d3 = blk[c < 3 ? c : 3];
            checks++;
            if (r3 !== (c < 3)) begin
                errors++;
                $display("FAIL stall_in_ready c=%0d: got %b want %b", c, r3, (c < 3));
            end
            checks++;
            if (ov3 !== (c >= 3) || (c >= 3 && (od3 !== xf(1'b0, blk[0]) || om3 !== 1'b0))) begin
                errors++;
                $display("FAIL stall_hold c=%0d: got v=%b m=%b d=%h want v=%b d=%h", c, ov3, om3, od3, (c >= 3), xf(1'b0, blk[0]));
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            v3 = 0; or3 = 1;
            checks++;
            if (ov3 !== (c < 3) || (c < 3 && (om3 !== 1'(c % 2) || od3 !== xf(1'(c % 2), blk[c])))) begin
                errors++;
                $display("FAIL stall_drain c=%0d: got v=%b m=%b d=%h want v=%b", c, ov3, om3, od3, (c < 3));
            end
            $display("drain c=%0d valid=%b data=%h", c, ov3, od3);
        end
        checks++;
        if (c3 !== 16'd3) begin
            errors++;
            $display("FAIL stall_blk_cnt: got %0d want 3", c3);
        end
    endtask

    task automatic test_mid_reset();
        int stale = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            v3 = 1; m3 = 0; d3 = 64'h5A5A_0000_0000_0001 + 64'(c); or3 = 1;
        end
        @(negedge clk);
        v3 = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (ov3 !== 1'b0 || c3 !== 16'd0 || od3 !== 64'd0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%b cnt=%0d d=%h want 0 0 0", ov3, c3, od3);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov3 !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL midreset_stale: %0d cycles with out_valid after reset, want 0", stale);
        end
        $display("midreset: pipeline flushed");
    endtask

    task automatic test_wrap();
        @(negedge clk);
        v1 = 1; m1 = 0; d1 = 64'h0000_1111_2222_3333; or1 = 1;
        repeat (65535) @(negedge clk);
        v1 = 0;
        @(negedge clk);
        checks++;
        if (c1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff: got %h want ffff", c1);
        end
        v1 = 1;
        @(negedge clk);
        v1 = 0;
        @(negedge clk);
        checks++;
        if (c1 !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h want 0000", c1);
        end
        $display("wrap: blk_cnt rolled over");
    endtask

    task automatic test_selfcheck();
        checks++;
        if ({e1, e3, e4} !== 3'b000) begin
            errors++;
            $display("FAIL chk_err_clean: got %b%b%b want 000", e1, e3, e4);
        end
`ifdef BORON_XOR_SELFCHECK_EN
        @(negedge clk);
        v1 = 1; m1 = 1; d1 = 64'h0001_0002_0004_0008; or1 = 1;
        @(negedge clk);
        v1 = 0;
        force u1.out_data = xf(1'b1, 64'h0001_0002_0004_0008) ^ 64'h1;
        @(posedge clk);
        #1 release u1.out_data;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (e1 !== 1'b1) begin
                errors++;
                $display("FAIL chk_err_sticky c=%0d: got %b want 1", c, e1);
            end
        end
        @(negedge clk) rst = 1;
        @(negedge clk) rst = 0;
        checks++;
        if (e1 !== 1'b0) begin
            errors++;
            $display("FAIL chk_err_reset: got %b want 0", e1);
        end
`endif
        $display("selfcheck: chk_err observed");
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 64'h0001_0002_0004_0008, 64'h0003_000E_0007_000C);
        test_single(1'b1, 64'h0003_000E_0007_000C, 64'h0001_0002_0004_0008);
        test_roundtrip();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        test_wrap();
        test_selfcheck();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
